// File: rtl/barrel_shifter_16_bit.sv
// 16-bit shift/rotate unit with a log-structured mux datapath; latency is one enabled Clock_In edge.
// No backpressure: Enable_In=0 holds the registered result, and Reset_In clears it asynchronously.
module barrel_shifter_16_bit (
  input  logic        Clock_In,
  input  logic        Reset_In,
  input  logic        Enable_In,
  input  logic [2:0]  Shifter_Mode_In,
  input  logic [3:0]  Shift_Bits_Length_In,
  input  logic        Carry_In,
  input  logic [15:0] Data_In,
  output logic [15:0] Shifted_Data_Out,
  output logic        Carry_Out
);

  typedef enum logic [2:0] {
    MODE_LSL = 3'd0,
    MODE_LSR = 3'd1,
    MODE_ASL = 3'd2,
    MODE_ASR = 3'd3,
    MODE_ROL = 3'd4,
    MODE_ROR = 3'd5,
    MODE_RCL = 3'd6,
    MODE_RCR = 3'd7
  } shift_mode_e;

  logic [16:0] left_v;
  logic [16:0] right_v;
  logic [15:0] rot_v;
  logic [16:0] rc_v;
  logic [15:0] next_dat;
  logic        next_carry;
  shift_mode_e mode;

  assign mode = shift_mode_e'(Shifter_Mode_In);

  // The carry rides along as a 17th bit, so bit 16 (left) or bit 0 (right)
  // ends up holding the last bit shifted out, or Carry_In when n=0.
  always_comb begin
    left_v  = {Carry_In, Data_In};
    right_v = {Data_In, Carry_In};
    rot_v   = Data_In;
    rc_v    = {Carry_In, Data_In};
    for (int k = 0; k < 4; k++) begin
      if (Shift_Bits_Length_In[k]) begin
        left_v = left_v << (1 << k);
        if (mode == MODE_ASR)
          right_v = 17'($signed(right_v) >>> (1 << k));
        else
          right_v = right_v >> (1 << k);
        if (mode == MODE_ROL)
          rot_v = (rot_v << (1 << k)) | (rot_v >> (16 - (1 << k)));
        else
          rot_v = (rot_v >> (1 << k)) | (rot_v << (16 - (1 << k)));
        if (mode == MODE_RCL)
          rc_v = (rc_v << (1 << k)) | (rc_v >> (17 - (1 << k)));
        else
          rc_v = (rc_v >> (1 << k)) | (rc_v << (17 - (1 << k)));
      end
    end
  end

  always_comb begin
    next_dat   = Data_In;
    next_carry = Carry_In;
    case (mode)
      MODE_LSL, MODE_ASL: begin
        next_dat   = left_v[15:0];
        next_carry = left_v[16];
      end
      MODE_LSR, MODE_ASR: begin
        next_dat   = right_v[16:1];
        next_carry = right_v[0];
      end
      MODE_ROL: begin
        next_dat   = rot_v;
        next_carry = (Shift_Bits_Length_In == 4'd0) ? Carry_In : rot_v[0];
      end
      MODE_ROR: begin
        next_dat   = rot_v;
        next_carry = (Shift_Bits_Length_In == 4'd0) ? Carry_In : rot_v[15];
      end
      MODE_RCL, MODE_RCR: begin
        next_dat   = rc_v[15:0];
        next_carry = rc_v[16];
      end
      default: begin
        next_dat   = Data_In;
        next_carry = Carry_In;
      end
    endcase
  end

  always_ff @(posedge Clock_In or negedge Reset_In) begin
    if (!Reset_In) begin
      Shifted_Data_Out <= 16'h0000;
      Carry_Out        <= 1'b0;
    end else if (Enable_In) begin
      Shifted_Data_Out <= next_dat;
      Carry_Out        <= next_carry;
    end
  end

endmodule

// File: tb/tb_barrel_shifter_16_bit.sv
// Self-checking bench: directed vector table, reset/enable sequences and a random
// sweep checked through an expected-result queue against a one-bit-per-step model.
module tb_barrel_shifter_16_bit;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [2:0]  mode;
  logic [3:0]  amt;
  logic        cin;
  logic [15:0] din;
  logic [15:0] dout;
  logic        cout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] dat;
    logic        carry;
    string       name;
  } exp_t;

  typedef struct {
    logic [2:0]  mode;
    logic [3:0]  n;
    logic        cin;
    logic [15:0] d;
    logic [15:0] ed;
    logic        ec;
    string       name;
  } vec_t;

  exp_t        sb[$];
  logic [15:0] last_dat;
  logic        last_carry;

  barrel_shifter_16_bit dut (
    .Clock_In             (clk),
    .Reset_In             (rst_n),
    .Enable_In            (en),
    .Shifter_Mode_In      (mode),
    .Shift_Bits_Length_In (amt),
    .Carry_In             (cin),
    .Data_In              (din),
    .Shifted_Data_Out     (dout),
    .Carry_Out            (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: apply n single-bit steps, tracking the carry bit explicitly.
  function automatic logic [16:0] model(input logic [2:0] m, input logic [3:0] n,
                                        input logic c_in, input logic [15:0] d);
    logic [15:0] r;
    logic        c;
    logic [16:0] t;
    r = d;
    c = c_in;
    for (int i = 0; i < int'(n); i++) begin
      case (m)
        3'd0, 3'd2: begin c = r[15]; r = {r[14:0], 1'b0}; end
        3'd1:       begin c = r[0];  r = {1'b0, r[15:1]}; end
        3'd3:       begin c = r[0];  r = {r[15], r[15:1]}; end
        3'd4:       begin r = {r[14:0], r[15]}; c = r[0]; end
        3'd5:       begin r = {r[0], r[15:1]};  c = r[15]; end
        3'd6:       begin t = {c, r}; t = {t[15:0], t[16]}; c = t[16]; r = t[15:0]; end
        default:    begin t = {c, r}; t = {t[0], t[16:1]};  c = t[16]; r = t[15:0]; end
      endcase
    end
    return {c, r};
  endfunction

  task automatic check(input string name, input logic [15:0] got_d, input logic got_c,
                       input logic [15:0] exp_d, input logic exp_c);
    checks++;
    if (got_d !== exp_d || got_c !== exp_c) begin
      errors++;
      $display("FAIL %s: got data=%h carry=%b, expected data=%h carry=%b",
               name, got_d, got_c, exp_d, exp_c);
    end
  endtask

  // Drive one cycle of stimulus, push the expected output, compare after the edge.
  task automatic step(input logic e, input logic [2:0] m, input logic [3:0] n,
                      input logic c, input logic [15:0] d, input string name,
                      input logic use_exp, input logic [15:0] ed, input logic ec);
    exp_t        x;
    logic [16:0] mr;
    @(negedge clk);
    en = e; mode = m; amt = n; cin = c; din = d;
    if (e) begin
      if (use_exp) begin
        x.dat = ed; x.carry = ec;
      end else begin
        mr = model(m, n, c, d);
        x.dat = mr[15:0]; x.carry = mr[16];
      end
    end else begin
      x.dat = last_dat; x.carry = last_carry;
    end
    x.name = name;
    sb.push_back(x);
    last_dat = x.dat;
    last_carry = x.carry;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty, expected an entry", name);
    end else begin
      x = sb.pop_front();
      check(x.name, dout, cout, x.dat, x.carry);
    end
  endtask

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{3'd0, 4'd1,  1'b0, 16'h8001, 16'h0002, 1'b1, "lsl_8001_n1"};
    vecs[1]  = '{3'd3, 4'd4,  1'b0, 16'h8000, 16'hF800, 1'b0, "asr_8000_n4"};
    vecs[2]  = '{3'd5, 4'd1,  1'b0, 16'h0001, 16'h8000, 1'b1, "ror_0001_n1"};
    vecs[3]  = '{3'd6, 4'd1,  1'b0, 16'h8000, 16'h0000, 1'b1, "rcl_8000_n1"};
    vecs[4]  = '{3'd7, 4'd4,  1'b1, 16'h0001, 16'h3000, 1'b0, "rcr_0001_n4"};
    vecs[5]  = '{3'd0, 4'd15, 1'b0, 16'h0003, 16'h8000, 1'b1, "lsl_n15"};
    vecs[6]  = '{3'd1, 4'd15, 1'b0, 16'hC000, 16'h0001, 1'b1, "lsr_n15"};
    vecs[7]  = '{3'd3, 4'd15, 1'b1, 16'h8000, 16'hFFFF, 1'b0, "asr_n15"};
    vecs[8]  = '{3'd4, 4'd15, 1'b1, 16'h0001, 16'h8000, 1'b0, "rol_n15"};
    vecs[9]  = '{3'd7, 4'd15, 1'b1, 16'h0000, 16'h0002, 1'b0, "rcr_n15"};
    vecs[10] = '{3'd2, 4'd1,  1'b1, 16'h4000, 16'h8000, 1'b0, "asl_4000_n1"};
    vecs[11] = '{3'd1, 4'd1,  1'b0, 16'h0001, 16'h0000, 1'b1, "lsr_0001_n1"};
    for (int m = 0; m < 7; m++)
      vecs[12 + m] = '{3'(m), 4'd0, 1'b1, 16'h1234, 16'h1234, 1'b1, $sformatf("n0_mode%0d", m)};

    rst_n = 1'b0; en = 1'b0; mode = 3'd0; amt = 4'd0; cin = 1'b0; din = 16'h0;
    last_dat = 16'h0; last_carry = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dout, cout, 16'h0000, 1'b0);

    // Reset overrides enable while held across edges.
    en = 1'b1; mode = 3'd4; amt = 4'd3; cin = 1'b1; din = 16'hFFFF;
    @(posedge clk);
    #1;
    check("reset_over_enable", dout, cout, 16'h0000, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 3'd7, 4'd15, 1'b1, 16'h0001, "mode7_n0_style", 1'b0, 16'h0, 1'b0);
    step(1'b1, 3'd7, 4'd0, 1'b1, 16'h1234, "n0_mode7", 1'b1, 16'h1234, 1'b1);

    foreach (vecs[i])
      step(1'b1, vecs[i].mode, vecs[i].n, vecs[i].cin, vecs[i].d, vecs[i].name,
           1'b1, vecs[i].ed, vecs[i].ec);

    // Hold: inputs change under Enable_In=0, result must not move.
    step(1'b1, 3'd4, 4'd5, 1'b0, 16'hA5C3, "hold_load", 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b0, 3'(i), 4'(i * 3 + 1), 1'(i), 16'(16'h1111 * (i + 1)),
           $sformatf("hold_%0d", i), 1'b0, 16'h0, 1'b0);
    step(1'b1, 3'd1, 4'd4, 1'b1, 16'hF0F0, "after_hold", 1'b1, 16'h0F0F, 1'b0);

    // Asynchronous reset between edges discards the pending result.
    step(1'b1, 3'd0, 4'd0, 1'b1, 16'hBEEF, "pre_async_reset", 1'b1, 16'hBEEF, 1'b1);
    @(negedge clk);
    en = 1'b1; mode = 3'd0; amt = 4'd1; din = 16'h7777;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clears", dout, cout, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    check("async_reset_discard", dout, cout, 16'h0000, 1'b0);
    last_dat = 16'h0; last_carry = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 3'd5, 4'd4, 1'b0, 16'h1234, "first_after_reset", 1'b1, 16'h4123, 1'b0);

    // Random sweep across every mode and amount.
    for (int m = 0; m < 8; m++)
      for (int n = 0; n < 16; n++)
        step(1'b1, 3'(m), 4'(n), 1'($urandom_range(0, 1)), 16'($urandom),
             $sformatf("sweep_m%0d_n%0d", m, n), 1'b0, 16'h0, 1'b0);

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
